// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI-to-SRAM transaction sequencer.
//   - Default address/data widths and the two recognised command bytes.
//   - FSM state encoding and the latched burst direction.
package spi_sram_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int BITCNT_W   = 3;

    localparam logic [7:0] DEF_CMD_WRITE = 8'h02;
    localparam logic [7:0] DEF_CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_ERR
    } state_e;

    typedef enum logic {
        DIR_WRITE,
        DIR_READ
    } dir_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Bit position counter for one SPI byte.
// Ports:
//   sck_i        serial clock, counts on the rising edge
//   rst_n        asynchronous active-low reset
//   cs_n_i       chip select; while high the counter is held at zero
//   bitcnt_o     bit index of the bit being sampled on the next rising edge
//   byte_done_o  high when the next edge completes a byte (bitcnt == 7)
//   byte_start_o high when the next edge is the first bit of a byte (bitcnt == 0)
module spi_bit_counter
    import spi_sram_pkg::*;
(
    input  logic                sck_i,
    input  logic                rst_n,
    input  logic                cs_n_i,
    output logic [BITCNT_W-1:0] bitcnt_o,
    output logic                byte_done_o,
    output logic                byte_start_o
);

    logic [BITCNT_W-1:0] bitcnt_q;
    logic [BITCNT_W-1:0] bitcnt_d;

    // Wraps naturally from 7 to 0, so consecutive bytes need no extra clear.
    always_comb begin
        bitcnt_d = cs_n_i ? '0 : bitcnt_q + 1'b1;
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge sck_i or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
        end
    end

    assign bitcnt_o     = bitcnt_q;
    assign byte_done_o  = (bitcnt_q == '1);
    assign byte_start_o = (bitcnt_q == '0);

endmodule

// File: rtl/spi_sram_ctrl.sv
// SPI-slave transaction sequencer in front of a combinational-read SRAM.
// A frame (CS_n low) carries a command byte, an address byte and any number
// of data bytes, all LSB first. Write bursts pulse sram_we once per data
// byte; read bursts serialise SRAM words onto MISO. The address
// auto-increments per data byte and wraps at the top of the address space.
// Ports:
//   SCK        serial clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   CS_n       chip select, active low; high aborts any transaction
//   MOSI       serial data in, LSB first
//   MISO       serial data out, registered, LSB first
//   sram_addr  registered SRAM address
//   sram_din   registered SRAM write data
//   sram_dout  SRAM read data, combinational from sram_addr
//   sram_we    SRAM write enable, single-cycle pulse
//   busy       high whenever the sequencer is not idle
module spi_sram_ctrl
    import spi_sram_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] CMD_WRITE = DEF_CMD_WRITE,
    parameter logic [DATA_W-1:0] CMD_READ  = DEF_CMD_READ
) (
    input  logic              SCK,
    input  logic              rst_n,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              sram_we,
    output logic              busy
);

    state_e              state_q;
    dir_e                dir_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   rx_d;
    logic [DATA_W-1:0]   tx_q;
    logic [ADDR_W-1:0]   sram_addr_q;
    logic [ADDR_W-1:0]   sram_addr_inc;
    logic [DATA_W-1:0]   sram_din_q;
    logic                sram_we_q;
    logic                miso_q;

    logic [BITCNT_W-1:0] bitcnt;
    logic                byte_done;
    logic                byte_start;

    spi_bit_counter u_bit_counter (
        .sck_i        (SCK),
        .rst_n        (rst_n),
        .cs_n_i       (CS_n),
        .bitcnt_o     (bitcnt),
        .byte_done_o  (byte_done),
        .byte_start_o (byte_start)
    );

    // The byte being completed on this edge includes the MOSI bit now on the pin.
    assign rx_d          = {MOSI, rx_q[DATA_W-1:1]};
    assign sram_addr_inc = sram_addr_q + ADDR_W'(1);

    always_ff @(posedge SCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_WRITE;
            rx_q        <= '0;
            tx_q        <= '0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            sram_we_q   <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            // NOTE: these defaults make sram_we a one-cycle pulse and keep
            // MISO low outside read bursts; branches below only override them.
            sram_we_q <= 1'b0;
            miso_q    <= 1'b0;

            if (CS_n) begin
                // Abort: a partial byte is simply forgotten because the bit
                // counter restarts at zero on the next frame.
                state_q <= ST_IDLE;
            end else begin
                rx_q <= rx_d;

                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_CMD;
                    end

                    ST_CMD: begin
                        if (byte_done) begin
                            if (rx_d == CMD_WRITE) begin
                                dir_q   <= DIR_WRITE;
                                state_q <= ST_ADDR;
                            end else if (rx_d == CMD_READ) begin
                                dir_q   <= DIR_READ;
                                state_q <= ST_ADDR;
                            end else begin
                                state_q <= ST_ERR;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (byte_done) begin
                            sram_addr_q <= rx_d[ADDR_W-1:0];
                            state_q     <= (dir_q == DIR_READ) ? ST_RDATA : ST_WDATA;
                        end
                    end

                    ST_WDATA: begin
                        // Advance only after the write cycle, so the address
                        // is stable for the whole cycle WE is high.
                        if (sram_we_q) begin
                            sram_addr_q <= sram_addr_inc;
                        end
                        if (byte_done) begin
                            sram_din_q <= rx_d;
                            sram_we_q  <= 1'b1;
                        end
                    end

                    ST_RDATA: begin
                        // Bit 0 comes straight from the SRAM; the word is kept
                        // in tx_q because the address moves before bit 7 is used.
                        if (byte_start) begin
                            tx_q   <= sram_dout;
                            miso_q <= sram_dout[0];
                        end else begin
                            miso_q <= tx_q[bitcnt];
                        end
                        if (byte_done) begin
                            sram_addr_q <= sram_addr_inc;
                        end
                    end

                    ST_ERR: begin
                        state_q <= ST_ERR;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign MISO      = miso_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;
    assign sram_we   = sram_we_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Self-checking bench for spi_sram_ctrl: a table of directed frames, hand
// sequences for abort and asynchronous reset, then randomized frames checked
// against a frame-level reference model (memory array + expected address).
module tb_spi_sram_ctrl;

    logic       SCK   = 1'b0;
    logic       rst_n = 1'b1;
    logic       CS_n  = 1'b1;
    logic       MOSI  = 1'b0;
    logic       MISO;
    logic [7:0] sram_addr;
    logic [7:0] sram_din;
    logic [7:0] sram_dout;
    logic       sram_we;
    logic       busy;

    int passed = 0;
    int total  = 0;

    // Environment SRAM and reference-model memory.
    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] ref_addr = 8'h00;

    logic [15:0] we_log [$];
    int          we_wide = 0;
    logic        we_prev = 1'b0;

    assign sram_dout = mem[sram_addr];

    always #5 SCK = ~SCK;

    spi_sram_ctrl dut (
        .SCK       (SCK),
        .rst_n     (rst_n),
        .CS_n      (CS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .sram_we   (sram_we),
        .busy      (busy)
    );

    // SRAM write port plus a log of every write and of over-long WE pulses.
    always @(posedge SCK) begin
        if (sram_we) begin
            mem[sram_addr] = sram_din;
            we_log.push_back({sram_addr, sram_din});
        end
        if (sram_we && we_prev) we_wide++;
        we_prev = sram_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One byte with CS_n low; returns the MISO bit seen after each edge,
    // which is the value the master samples on the following edge.
    task automatic xfer_byte(input logic [7:0] b, output logic [7:0] rx);
        for (int i = 0; i < 8; i++) begin
            @(negedge SCK);
            CS_n = 1'b0;
            MOSI = b[i];
            @(posedge SCK);
            #1;
            rx[i] = MISO;
        end
    endtask

    task automatic end_frame();
        @(negedge SCK);
        CS_n = 1'b1;
        MOSI = 1'b0;
        @(posedge SCK);
        #1;
    endtask

    // Full frame {cmd, addr, n data bytes}, checked against the reference model.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                             input int n, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int nwe);
        logic [7:0]  m;
        logic [7:0]  a;
        logic [31:0] exp_rd;
        int          exp_we;
        exp_rd = 32'h0;
        exp_we = 0;
        rdata  = 32'h0;
        we_log.delete();
        we_wide = 0;

        xfer_byte(cmd, m);
        check({tag, " miso_cmd"}, {24'h0, m}, 32'h0);
        check({tag, " busy_in_frame"}, {31'h0, busy}, 32'h1);
        xfer_byte(addr, m);
        check({tag, " miso_addr"}, {24'h0, m}, 32'h0);
        for (int j = 0; j < n; j++) begin
            xfer_byte((cmd == 8'h02) ? wdata[8*j +: 8] : 8'h00, m);
            rdata[8*j +: 8] = m;
        end
        end_frame();
        check({tag, " busy_after"}, {31'h0, busy}, 32'h0);

        if (cmd == 8'h02) begin
            exp_we = n;
            for (int j = 0; j < n; j++) begin
                a = addr + 8'(j);
                ref_mem[a] = wdata[8*j +: 8];
                if (j < we_log.size())
                    check({tag, " we_entry"}, {16'h0, we_log[j]}, {16'h0, a, wdata[8*j +: 8]});
            end
            ref_addr = addr + 8'(n - 1);
        end else if (cmd == 8'h03) begin
            for (int j = 0; j < n; j++) begin
                a = addr + 8'(j);
                exp_rd[8*j +: 8] = ref_mem[a];
            end
            ref_addr = addr + 8'(n);
        end
        check({tag, " we_count"}, we_log.size(), exp_we);
        check({tag, " we_width"}, we_wide, 0);
        check({tag, " read_data"}, rdata, exp_rd);
        check({tag, " final_addr"}, {24'h0, sram_addr}, {24'h0, ref_addr});
        nwe = we_log.size();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        logic [31:0] wdata;
        int          exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] rd;
        int          nwe;
        logic [7:0]  m;
        logic [7:0]  a;

        vecs[0] = '{8'h02, 8'h10, 1, 32'h0000_00A5, 1, 8'h10, 32'h0000_0000};
        vecs[1] = '{8'h03, 8'h10, 1, 32'h0000_0000, 0, 8'h11, 32'h0000_00A5};
        vecs[2] = '{8'h02, 8'hFE, 3, 32'h0033_2211, 3, 8'h00, 32'h0000_0000};
        vecs[3] = '{8'h03, 8'hFE, 3, 32'h0000_0000, 0, 8'h01, 32'h0033_2211};
        vecs[4] = '{8'h9F, 8'h00, 1, 32'h0000_00FF, 0, 8'h01, 32'h0000_0000};
        vecs[5] = '{8'h02, 8'h40, 2, 32'h0000_C35A, 2, 8'h41, 32'h0000_0000};
        vecs[6] = '{8'h03, 8'h40, 2, 32'h0000_0000, 0, 8'h42, 32'h0000_C35A};

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        check("reset miso", {31'h0, MISO}, 32'h0);
        check("reset addr", {24'h0, sram_addr}, 32'h0);
        check("reset din", {24'h0, sram_din}, 32'h0);
        check("reset we", {31'h0, sram_we}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        @(negedge SCK);
        rst_n = 1'b1;
        @(posedge SCK);
        #1;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].addr, vecs[v].n,
                      vecs[v].wdata, rd, nwe);
            check($sformatf("vec%0d tbl_we", v), nwe, vecs[v].exp_we);
            check($sformatf("vec%0d tbl_addr", v), {24'h0, sram_addr}, {24'h0, vecs[v].exp_addr});
            check($sformatf("vec%0d tbl_rd", v), rd, vecs[v].exp_rd);
        end

        // Abort mid data byte: no write, idle on the CS_n-high edge.
        we_log.delete();
        xfer_byte(8'h02, m);
        xfer_byte(8'h20, m);
        for (int i = 0; i < 4; i++) begin
            @(negedge SCK);
            CS_n = 1'b0;
            MOSI = 1'b1;
            @(posedge SCK);
        end
        #1;
        check("abort busy_before", {31'h0, busy}, 32'h1);
        end_frame();
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort we_count", we_log.size(), 0);
        ref_addr = 8'h20;
        check("abort addr", {24'h0, sram_addr}, 32'h20);
        run_frame("after_abort", 8'h02, 8'h21, 1, 32'h77, rd, nwe);

        // Asynchronous reset during WDATA bit 4.
        we_log.delete();
        xfer_byte(8'h02, m);
        xfer_byte(8'h30, m);
        for (int i = 0; i < 4; i++) begin
            @(negedge SCK);
            CS_n = 1'b0;
            MOSI = 1'b1;
            @(posedge SCK);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid addr", {24'h0, sram_addr}, 32'h0);
        check("rst_mid din", {24'h0, sram_din}, 32'h0);
        check("rst_mid we", {31'h0, sram_we}, 32'h0);
        check("rst_mid miso", {31'h0, MISO}, 32'h0);
        check("rst_mid busy", {31'h0, busy}, 32'h0);
        @(negedge SCK);
        CS_n  = 1'b1;
        MOSI  = 1'b0;
        rst_n = 1'b1;
        @(posedge SCK);
        #1;
        check("rst_mid we_count", we_log.size(), 0);
        ref_addr = 8'h00;

        // Randomized frames against the reference model.
        for (int t = 0; t < 40; t++) begin
            int          kind;
            int          n;
            logic [7:0]  cmd;
            logic [31:0] wd;
            kind = $urandom_range(0, 9);
            a    = 8'hF8 + 8'($urandom_range(0, 15));
            n    = $urandom_range(1, 4);
            wd   = $urandom;
            if (kind <= 3) begin
                run_frame($sformatf("rnd%0d wr", t), 8'h02, a, n, wd, rd, nwe);
            end else if (kind <= 7) begin
                run_frame($sformatf("rnd%0d rd", t), 8'h03, a, n, 32'h0, rd, nwe);
            end else if (kind == 8) begin
                cmd = 8'($urandom);
                while (cmd == 8'h02 || cmd == 8'h03) cmd = 8'($urandom);
                run_frame($sformatf("rnd%0d bad", t), cmd, a, n, wd, rd, nwe);
            end else begin
                we_log.delete();
                xfer_byte(8'h02, m);
                xfer_byte(a, m);
                for (int i = 0; i < n + 2; i++) begin
                    @(negedge SCK);
                    CS_n = 1'b0;
                    MOSI = wd[i];
                    @(posedge SCK);
                end
                end_frame();
                ref_addr = a;
                check($sformatf("rnd%0d abort we", t), we_log.size(), 0);
                check($sformatf("rnd%0d abort busy", t), {31'h0, busy}, 32'h0);
                check($sformatf("rnd%0d abort addr", t), {24'h0, sram_addr}, {24'h0, ref_addr});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
